// File: rtl/nec_div_sequencer.sv
// nec_div_sequencer: DIV/DIVU sequencer in front of the shared nec_divider.
// Optional minimum-latency padding: define NEC_DIV_CYCLE_PAD_EN.
module nec_div_sequencer #(
  parameter int PAD_WIDE = 38,
  parameter int PAD_BYTE = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_wide,
  input  logic [31:0] req_dividend,
  input  logic [15:0] req_divisor,
  input  logic        flush,
  output logic        div_start,
  output logic        div_wide,
  output logic [32:0] div_a,
  output logic [32:0] div_b,
  input  logic        div_done,
  input  logic        div_overflow,
  input  logic        div_dbz,
  input  logic [15:0] div_quot,
  input  logic [15:0] div_rem,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_quot,
  output logic [15:0] res_rem,
  output logic        res_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]  state;
  logic        sgn;
  logic        accept;
  logic        pad_hit;
  logic        sa_n;
  logic        sb_n;
  logic [32:0] a_n;
  logic [32:0] b_n;
  logic        q_sign;
  logic        err;
  logic [7:0]  q_ext;
  logic [7:0]  r_ext;
  logic [15:0] q_fmt;
  logic [15:0] r_fmt;

  assign req_ready = (state == S_IDLE);
  assign div_start = (state == S_ISSUE);
  assign res_valid = (state == S_RESP);
  assign accept    = req_ready & req_valid & ~flush;

  // Build sign-tagged divider operands from the raw request.
  always_comb begin
    sa_n = req_signed & (req_wide ? req_dividend[31] : req_dividend[15]);
    sb_n = req_signed & (req_wide ? req_divisor[15] : req_divisor[7]);
    if (req_wide) begin
      a_n = {sa_n, req_dividend};
      b_n = {sb_n, {16{sb_n}}, req_divisor};
    end else begin
      a_n = {sa_n, 16'b0, req_dividend[15:0]};
      b_n = {sb_n, {24{sb_n}}, req_divisor[7:0]};
    end
  end

  // Range/sign check of the divider result and byte-result extension.
  always_comb begin
    q_sign = div_wide ? div_quot[15] : div_quot[7];
    err = div_dbz | div_overflow
        | (sgn & (|div_quot) & (q_sign != (div_a[32] ^ div_b[32])))
        | (sgn & ~div_wide & (div_quot[15:8] != {8{div_quot[7]}}));
    q_ext = sgn ? {8{div_quot[7]}} : 8'b0;
    r_ext = sgn ? {8{div_rem[7]}} : 8'b0;
    q_fmt = div_wide ? div_quot : {q_ext, div_quot[7:0]};
    r_fmt = div_wide ? div_rem : {r_ext, div_rem[7:0]};
  end

`ifdef NEC_DIV_CYCLE_PAD_EN
  localparam logic [7:0] LIM_W = 8'(PAD_WIDE - 1);
  localparam logic [7:0] LIM_B = 8'(PAD_BYTE - 1);
  logic [7:0] pad_cnt;

  // Saturating ce-cycle count since accept; equals cycles elapsed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_cnt <= 8'd0;
    end else if (ce) begin
      if (accept) begin
        pad_cnt <= 8'd1;
      end else if (pad_cnt != 8'hFF) begin
        pad_cnt <= pad_cnt + 8'd1;
      end
    end
  end

  assign pad_hit = pad_cnt >= (div_wide ? LIM_W : LIM_B);
`else
  assign pad_hit = 1'b1;
`endif

  // Request/response sequencing and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sgn       <= 1'b0;
      div_wide  <= 1'b0;
      div_a     <= 33'd0;
      div_b     <= 33'd0;
      res_quot  <= 16'd0;
      res_rem   <= 16'd0;
      res_error <= 1'b0;
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_ISSUE;
            sgn      <= req_signed;
            div_wide <= req_wide;
            div_a    <= a_n;
            div_b    <= b_n;
          end
        end
        S_ISSUE: state <= flush ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (div_done) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              res_quot  <= q_fmt;
              res_rem   <= r_fmt;
              res_error <= err;
              state     <= pad_hit ? S_RESP : S_PAD;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_PAD: begin
          if (flush) state <= S_IDLE;
          else if (pad_hit) state <= S_RESP;
        end
        S_RESP: begin
          if (flush || res_ready) state <= S_IDLE;
        end
        S_DRAIN: begin
          if (div_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_div_sequencer.sv
// tb_nec_div_sequencer: vectors, random ops and flush/reset corners
// for nec_div_sequencer, with a behavioural divider model.
module tb_nec_div_sequencer;

  localparam int PAD_WIDE = 38;
  localparam int PAD_BYTE = 24;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_signed = 1'b0;
  logic        req_wide = 1'b0;
  logic [31:0] req_dividend = '0;
  logic [15:0] req_divisor = '0;
  logic        flush = 1'b0;
  logic        res_ready = 1'b0;
  logic        req_ready;
  logic        div_start;
  logic        div_wide;
  logic [32:0] div_a;
  logic [32:0] div_b;
  logic        div_done;
  logic        div_overflow;
  logic        div_dbz;
  logic [15:0] div_quot;
  logic [15:0] div_rem;
  logic        res_valid;
  logic [15:0] res_quot;
  logic [15:0] res_rem;
  logic        res_error;

  int total = 0;
  int bad = 0;
  int cecnt = 0;
  int starts = 0;
  int ce_mode = 0;

  always #5 clk = ~clk;

  nec_div_sequencer #(.PAD_WIDE(PAD_WIDE), .PAD_BYTE(PAD_BYTE)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_wide(req_wide),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .flush(flush), .div_start(div_start), .div_wide(div_wide),
    .div_a(div_a), .div_b(div_b), .div_done(div_done),
    .div_overflow(div_overflow), .div_dbz(div_dbz),
    .div_quot(div_quot), .div_rem(div_rem),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quot(res_quot), .res_rem(res_rem), .res_error(res_error)
  );

  always @(posedge clk) begin
    if (ce) begin
      cecnt <= cecnt + 1;
      if (div_start && reset_n) starts <= starts + 1;
    end
  end

  // Divider model: dbz done one ce-cycle after start, else 32.
  logic   busy;
  int     dcnt;
  longint am, bm, qm, rm;
  bit     sa, sb;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_done <= 1'b0; div_overflow <= 1'b0; div_dbz <= 1'b0;
      div_quot <= '0; div_rem <= '0; busy <= 1'b0; dcnt <= 0;
    end else if (ce) begin
      div_done <= 1'b0;
      if (div_start && !busy) begin
        sa = div_a[32];
        sb = div_b[32];
        if (div_wide) begin
          am = sa ? -longint'(int'(div_a[31:0])) : longint'(div_a[31:0]);
          bm = sb ? -longint'(shortint'(div_b[15:0])) : longint'(div_b[15:0]);
        end else begin
          am = sa ? -longint'(shortint'(div_a[15:0])) : longint'(div_a[15:0]);
          bm = sb ? -longint'(byte'(div_b[7:0])) : longint'(div_b[7:0]);
        end
        if (bm == 0) begin
          div_dbz <= 1'b1; div_overflow <= 1'b0; div_done <= 1'b1;
          div_quot <= '0; div_rem <= '0;
        end else begin
          qm = am / bm;
          rm = am % bm;
          div_dbz <= 1'b0;
          div_overflow <= (qm > (div_wide ? 65535 : 255));
          div_quot <= 16'((sa ^ sb) ? -qm : qm);
          div_rem <= 16'(sa ? -rm : rm);
          busy <= 1'b1;
          dcnt <= 31;
        end
      end else if (busy) begin
        if (dcnt == 1) begin
          div_done <= 1'b1;
          busy <= 1'b0;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    case (ce_mode)
      0: ce = 1'b1;
      1: ce = ~ce;
      default: ce = ($urandom & 1) != 0;
    endcase
  endtask

  // Reference: true integer division plus the architectural result range.
  function automatic void ref_div(input bit s, input bit w, input logic [31:0] dd,
                                  input logic [15:0] dv, output logic [15:0] q,
                                  output logic [15:0] r, output bit err);
    longint a, b, qq, rr, lo, hi;
    if (w) begin
      a = s ? longint'(int'(dd)) : longint'(dd);
      b = s ? longint'(shortint'(dv)) : longint'(dv);
      lo = s ? -32768 : 0;
      hi = s ? 32767 : 65535;
    end else begin
      a = s ? longint'(shortint'(dd[15:0])) : longint'(dd[15:0]);
      b = s ? longint'(byte'(dv[7:0])) : longint'(dv[7:0]);
      lo = s ? -128 : 0;
      hi = s ? 127 : 255;
    end
    q = '0;
    r = '0;
    if (b == 0) begin
      err = 1'b1;
    end else begin
      qq = a / b;
      rr = a % b;
      err = (qq < lo) || (qq > hi);
      q = 16'(qq);
      r = 16'(rr);
    end
  endfunction

  function automatic int exp_lat(input bit w, input bit z);
    int l;
    l = z ? 3 : 34;
`ifdef NEC_DIV_CYCLE_PAD_EN
    if (w && l < PAD_WIDE) l = PAD_WIDE;
    if (!w && l < PAD_BYTE) l = PAD_BYTE;
`endif
    return l;
  endfunction

  task automatic do_accept(input bit s, input bit w, input logic [31:0] dd,
                           input logic [15:0] dv, output int acc);
    int n;
    tick();
    req_signed = s; req_wide = w; req_dividend = dd; req_divisor = dv;
    req_valid = 1'b1;
    n = 0;
    while (!(ce && req_ready) && n < 400) begin
      tick();
      n++;
    end
    chk("accept_bound", 64'(n < 400), 64'd1);
    acc = cecnt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_op(input bit s, input bit w, input logic [31:0] dd,
                        input logic [15:0] dv, input logic [15:0] eq,
                        input logic [15:0] er, input bit ee, input string nm);
    int acc, n, st0;
    bit z, sA, sB;
    logic [32:0] ea, eb;
    z = w ? (dv == 16'd0) : (dv[7:0] == 8'd0);
    sA = s & (w ? dd[31] : dd[15]);
    sB = s & (w ? dv[15] : dv[7]);
    ea = w ? {sA, dd} : {sA, 16'b0, dd[15:0]};
    eb = w ? {sB, {16{sB}}, dv} : {sB, {24{sB}}, dv[7:0]};
    st0 = starts;
    do_accept(s, w, dd, dv, acc);
    chk({nm, " div_a"}, 64'(div_a), 64'(ea));
    chk({nm, " div_b"}, 64'(div_b), 64'(eb));
    chk({nm, " div_wide"}, 64'(div_wide), 64'(w));
    n = 0;
    while (!res_valid && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, 64'(cecnt - acc), 64'(exp_lat(w, z)));
    chk({nm, " error"}, 64'(res_error), 64'(ee));
    if (!ee) begin
      chk({nm, " quot"}, 64'(res_quot), 64'(eq));
      chk({nm, " rem"}, 64'(res_rem), 64'(er));
    end
    chk({nm, " ready_in_resp"}, 64'(req_ready), 64'd0);
    chk({nm, " one_start"}, 64'(starts - st0), 64'd1);
    tick();
    tick();
    chk({nm, " held"}, 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    n = 0;
    while (res_valid && n < 400) begin
      tick();
      n++;
    end
    res_ready = 1'b0;
    chk({nm, " back_idle"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    bit          s;
    bit          w;
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    bit          err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int acc, n, st0;
    bit seen, s, w, ee;
    logic [31:0] dd;
    logic [15:0] dv, eq, er;

    tbl[0] = '{0, 1, 32'h0001_0000, 16'h0010, 16'h1000, 16'h0000, 0};
    tbl[1] = '{1, 0, 32'hABCD_FFF9, 16'h5502, 16'hFFFD, 16'hFFFF, 0};
    tbl[2] = '{0, 1, 32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1};
    tbl[3] = '{1, 1, 32'h0000_8000, 16'h0001, 16'h0000, 16'h0000, 1};
    tbl[4] = '{1, 1, 32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 0};
    tbl[5] = '{1, 0, 32'h0000_0080, 16'h0001, 16'h0000, 16'h0000, 1};
    tbl[6] = '{1, 0, 32'h0000_FF80, 16'h0001, 16'hFF80, 16'h0000, 0};
    tbl[7] = '{0, 0, 32'h0000_FEFF, 16'h00FF, 16'h00FF, 16'h00FE, 0};
    tbl[8] = '{1, 1, 32'h8000_0000, 16'hFFFF, 16'h0000, 16'h0000, 1};

    ce = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst strobes", 64'({div_start, res_valid, res_error, div_wide}), 64'd0);
    chk("rst results", 64'({res_quot, res_rem}), 64'd0);
    chk("rst operands", {div_a[31:0], div_b[31:0]} ^ 64'(div_a[32] | div_b[32]), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].s, tbl[i].w, tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r,
             tbl[i].err, $sformatf("vec%0d", i));

    ce_mode = 1;
    run_op(0, 1, 32'h0001_0000, 16'h0010, 16'h1000, 16'h0000, 0, "ce_half");
    ce_mode = 0;

    // flush in WAIT five ce-cycles after accept
    do_accept(0, 1, 32'h0000_4000, 16'h0004, acc);
    while (cecnt - acc < 5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain ready", 64'(req_ready), 64'd0);
    seen = 0;
    n = 0;
    while (!req_ready && n < 100) begin
      if (res_valid) seen = 1;
      tick();
      n++;
    end
    chk("drain no_valid", 64'(seen), 64'd0);
    chk("drain exit", 64'(cecnt - acc), 64'd34);
    run_op(1, 0, 32'h0000_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, "after_drain");

    // flush while in ISSUE: start still goes out, then drain
    st0 = starts;
    do_accept(0, 1, 32'h0000_0100, 16'h0002, acc);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("issue_flush ready", 64'(req_ready), 64'd0);
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("issue_flush start", 64'(starts - st0), 64'd1);
    chk("issue_flush exit", 64'(cecnt - acc), 64'd34);

    // flush during RESP discards the result
    do_accept(0, 0, 32'h0000_0064, 16'h000A, acc);
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("resp reached", 64'(res_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("resp_flush valid", 64'(res_valid), 64'd0);
    chk("resp_flush ready", 64'(req_ready), 64'd1);

    // flush wins over a request in IDLE
    tick();
    st0 = starts;
    req_valid = 1'b1;
    flush = 1'b1;
    tick();
    chk("idle_flush ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    flush = 1'b0;
    tick();
    chk("idle_flush no_start", 64'(starts - st0), 64'd0);

    // flush together with div_done returns straight to IDLE
    do_accept(0, 1, 32'h0000_0900, 16'h0003, acc);
    while (cecnt - acc < 33) tick();
    chk("done_flush done", 64'(div_done), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush ready", 64'(req_ready), 64'd1);
    chk("done_flush valid", 64'(res_valid), 64'd0);

    // asynchronous reset mid-operation
    do_accept(1, 1, 32'hFFFF_FF00, 16'h0010, acc);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst ready", 64'(req_ready), 64'd1);
    chk("midrst div_a", 64'(div_a), 64'd0);
    chk("midrst start", 64'(div_start), 64'd0);
    tick();
    reset_n = 1'b1;
    run_op(0, 1, 32'h0001_0000, 16'h0010, 16'h1000, 16'h0000, 0, "after_rst");

    ce_mode = 2;
    for (int i = 0; i < 20; i++) begin
      s = ($urandom & 1) != 0;
      w = ($urandom & 1) != 0;
      dd = $urandom >> ($urandom_range(31, 0));
      dv = 16'($urandom >> ($urandom_range(24, 16)));
      if ($urandom_range(9, 0) == 0) dv = 16'h0000;
      ref_div(s, w, dd, dv, eq, er, ee);
      run_op(s, w, dd, dv, eq, er, ee, $sformatf("rand%0d", i));
    end
    ce_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
